// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   state_e : FSM state encoding (IDLE, RUN, FIX, DONE)
//   op_e    : operation select encodings (OP_MULT, OP_DIV)
//   CNT_W   : width of the iteration counter (covers WIDTH up to 255)
package md_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

   localparam int CNT_W = 8;

endpackage

// File: rtl/md_sequencer_if.sv
// Request/result bundle of the multiply/divide sequencer.
//   start, op, a, b          : request side (driven by master)
//   busy, done, hi, lo,
//   div_zero                 : status/result side (driven by slave)
interface md_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/md_step.sv
// One combinational iteration of the sequencer datapath.
//   op_i  : OP_MULT -> one radix-2 Booth step, OP_DIV -> one restoring step
//   m_i   : multiplicand (signed, multiply) or divisor magnitude (divide)
//   acc_i : working register {upper[WIDTH:0], low[WIDTH-1:0], lsb}
//           multiply: {A, Q, q_minus1}; divide: {remainder, quotient, 0}
//   acc_o : working register after the iteration
module md_step
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               op_i,
   input  logic [WIDTH-1:0]   m_i,
   input  logic [2*WIDTH+1:0] acc_i,
   output logic [2*WIDTH+1:0] acc_o
);

   // The upper half carries one guard bit so that subtracting the most
   // negative multiplicand cannot overflow before the arithmetic shift.
   logic [WIDTH:0]     upper;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH:0]     m_sext;
   logic [WIDTH:0]     m_zext;
   logic [WIDTH:0]     booth_sum;
   logic [2*WIDTH+1:0] booth_pre;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     trial;

   always_comb begin
      upper  = acc_i[2*WIDTH+1:WIDTH+1];
      quo    = acc_i[WIDTH:1];
      m_sext = {m_i[WIDTH-1], m_i};
      m_zext = {1'b0, m_i};

      booth_sum = upper;
      case (acc_i[1:0])
         2'b01:   booth_sum = upper + m_sext;
         2'b10:   booth_sum = upper - m_sext;
         default: booth_sum = upper;
      endcase
      booth_pre = {booth_sum, acc_i[WIDTH:0]};

      // Shift the next dividend bit (quotient MSB) into the remainder and
      // try subtracting the divisor; a set sign bit means restore.
      rem_shift = {upper[WIDTH-1:0], quo[WIDTH-1]};
      trial     = rem_shift - m_zext;

      if (op_i == OP_DIV) begin
         if (trial[WIDTH]) begin
            acc_o = {rem_shift, quo[WIDTH-2:0], 1'b0, 1'b0};
         end else begin
            acc_o = {trial, quo[WIDTH-2:0], 1'b1, 1'b0};
         end
      end else begin
         acc_o = {booth_pre[2*WIDTH+1], booth_pre[2*WIDTH+1:1]};
      end
   end

endmodule

// File: rtl/md_sequencer.sv
// Iterative signed multiply / divide unit with architectural HI/LO registers.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : md_sequencer_if.slave
//           start/op/a/b in; busy/done/hi/lo/div_zero out
// Multiply: hi:lo = a * b (signed 2*WIDTH product).
// Divide  : lo = a / b truncated toward zero, hi = remainder (sign of a).
// Divide by zero skips iteration, sets div_zero and leaves hi/lo untouched.
module md_sequencer
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   md_sequencer_if.slave  bus
);

   localparam int ACC_W = 2*WIDTH + 2;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               div_zero_q, div_zero_d;

   logic [ACC_W-1:0]   step_acc;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag;

   md_step #(.WIDTH(WIDTH)) u_step (
      .op_i  (op_q),
      .m_i   (m_q),
      .acc_i (acc_q),
      .acc_o (step_acc)
   );

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
   // as an unsigned number, which the divider handles correctly.
   assign a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign quo_mag = acc_q[WIDTH:1];
   assign rem_mag = acc_q[2*WIDTH:WIDTH+1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      m_d        = m_q;
      acc_d      = acc_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      zero_d     = zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d       = bus.op;
               cnt_d      = '0;
               div_zero_d = 1'b0;
               neg_quo_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               neg_rem_d  = bus.a[WIDTH-1];
               if (bus.op == OP_DIV) begin
                  acc_d  = {{(WIDTH+1){1'b0}}, a_mag, 1'b0};
                  m_d    = b_mag;
                  zero_d = (bus.b == '0);
                  // Zero divisor bypasses iteration; FIX only raises the flag.
                  state_d = (bus.b == '0) ? ST_FIX : ST_RUN;
               end else begin
                  acc_d   = {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
                  m_d     = bus.a;
                  zero_d  = 1'b0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (zero_q) begin
               div_zero_d = 1'b1;
            end else if (op_q == OP_DIV) begin
               lo_d = neg_quo_q ? -quo_mag : quo_mag;
               hi_d = neg_rem_q ? -rem_mag : rem_mag;
            end else begin
               hi_d = acc_q[2*WIDTH:WIDTH+1];
               lo_d = acc_q[WIDTH:1];
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= 1'b0;
         m_q        <= '0;
         acc_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         zero_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         m_q        <= m_d;
         acc_q      <= acc_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         zero_q     <= zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: each request pushes its expected
// hi/lo/div_zero/latency; the entry is popped and compared at done.
module tb_md_sequencer;
   import md_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   md_sequencer_if #(.WIDTH(W)) bus ();

   md_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t         scb[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] mdl_hi = '0;
   logic [W-1:0] mdl_lo = '0;
   logic         mdl_dz = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sbv, p, q, r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (op == OP_MULT) begin
         p      = sa * sbv;
         mdl_hi = p[63:32];
         mdl_lo = p[31:0];
         mdl_dz = 1'b0;
         e.lat  = 34;
      end else if (b == '0) begin
         mdl_dz = 1'b1;
         e.lat  = 2;
      end else begin
         q      = sa / sbv;
         r      = sa % sbv;
         mdl_lo = q[31:0];
         mdl_hi = r[31:0];
         mdl_dz = 1'b0;
         e.lat  = 34;
      end
      e.hi = mdl_hi;
      e.lo = mdl_lo;
      e.dz = mdl_dz;
      scb.push_back(e);
   endtask

   // Issue one request; optionally inject an ignored divide request at
   // cycle intrude_at of the operation.
   task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intrude_at);
      exp_t         e;
      int           edges;
      logic         seen;
      logic [W-1:0] hold_hi, hold_lo;
      hold_hi = mdl_hi;
      hold_lo = mdl_lo;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      push_exp(op, a, b);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         bus.start = 1'b0;
         if (intrude_at != 0 && edges == intrude_at) begin
            bus.start = 1'b1;
            bus.op    = OP_DIV;
            bus.a     = 32'd100;
            bus.b     = 32'd7;
         end
         if (edges == 1) check_eq("busy_running", 64'(bus.busy), 64'd1);
         if (edges == 20) begin
            check_eq("hold_hi", 64'(bus.hi), 64'(hold_hi));
            check_eq("hold_lo", 64'(bus.lo), 64'(hold_lo));
         end
         seen = bus.done;
      end
      e = scb.pop_front();
      check_eq("done_seen", 64'(seen), 64'd1);
      check_eq("latency", 64'(edges), 64'(e.lat));
      check_eq("hi", 64'(bus.hi), 64'(e.hi));
      check_eq("lo", 64'(bus.lo), 64'(e.lo));
      check_eq("div_zero", 64'(bus.div_zero), 64'(e.dz));
      $display("txn op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d lat=%0d",
               op, a, b, bus.hi, bus.lo, bus.div_zero, edges);
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("done_one_pulse", 64'(bus.done), 64'd0);
      check_eq("back_idle", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int extra;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Power-up reset.
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      check_eq("rst_hi", 64'(bus.hi), 64'd0);
      check_eq("rst_lo", 64'(bus.lo), 64'd0);
      check_eq("rst_dz", 64'(bus.div_zero), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0);
      do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0);
      do_op(OP_DIV, 32'd5, 32'd0, 0);

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] ra, rb;
         logic         rop;
         rop = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? (32'($urandom_range(1, 20)) * ((i % 4 == 0) ? 32'hFFFF_FFFF : 32'd1))
                            : $urandom;
         do_op(rop, ra, rb, 0);
      end

      // Request during an operation must be ignored.
      do_op(OP_MULT, 32'd3, 32'd4, 10);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) extra++;
      end
      check_eq("no_extra_done", 64'(extra), 64'd0);
      check_eq("intrude_hi", 64'(bus.hi), 64'd0);
      check_eq("intrude_lo", 64'(bus.lo), 64'd12);

      // Reset in the middle of an operation.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq("midrst_busy", 64'(bus.busy), 64'd0);
      check_eq("midrst_done", 64'(bus.done), 64'd0);
      check_eq("midrst_hi", 64'(bus.hi), 64'd0);
      check_eq("midrst_lo", 64'(bus.lo), 64'd0);
      $display("txn reset mid-operation -> busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
      mdl_hi = '0;
      mdl_lo = '0;
      mdl_dz = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      do_op(OP_MULT, 32'd2, 32'd3, 0);

      check_eq("scoreboard_empty", 64'(scb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
